// File: rtl/ut_datapath.sv
`default_nettype none
// ============================================================================
// Module   : ut_datapath
// Brief    : Accumulator-CPU processing-unit datapath. Holds PC, RI, R1,
//            ACCU and the carry flag, and contains the ALU. Every register
//            update is driven directly by the control FSM strobes.
// Revision : 1.0 - initial release
// ============================================================================
module ut_datapath #(
  parameter int DATA_W = 8,  // must be >= ADDR_W+3 (opcode sits above the address field)
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce,
  input  logic              clear_PC,
  input  logic              enable_PC,
  input  logic              load_PC,
  input  logic              load_RI,
  input  logic              sel_ADR,
  input  logic              load_R1,
  input  logic              load_ACCU,
  input  logic [2:0]        sel_UAL,
  input  logic              clear_carry,
  input  logic              load_carry,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [2:0]        code_op,
  output logic              carry,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] accu_dbg
);

  localparam logic [2:0] ALU_NOR = 3'b000;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b011;

  logic [ADDR_W-1:0] pc_q,    pc_d;
  logic [DATA_W-1:0] ri_q,    ri_d;
  logic [DATA_W-1:0] r1_q,    r1_d;
  logic [DATA_W-1:0] accu_q,  accu_d;
  logic              carry_q, carry_d;

  logic [DATA_W:0]   alu_wide;
  logic [DATA_W-1:0] alu_res;
  logic              alu_cout;

  // ALU: A = ACCU, B = R1, evaluated one extra bit wide to expose carry-out
  always_comb begin
    case (sel_UAL)
      ALU_NOR: alu_wide = {1'b0, ~(accu_q | r1_q)};
      ALU_ADD: alu_wide = {1'b0, accu_q} + {1'b0, r1_q};
      ALU_SUB: alu_wide = {1'b0, accu_q} + {1'b0, ~r1_q} + {{DATA_W{1'b0}}, 1'b1};
      default: alu_wide = {1'b0, accu_q};
    endcase
    alu_res  = alu_wide[DATA_W-1:0];
    alu_cout = alu_wide[DATA_W];
  end

  // Next-state selection; every load reads pre-edge register values
  always_comb begin
    pc_d    = pc_q;
    ri_d    = ri_q;
    r1_d    = r1_q;
    accu_d  = accu_q;
    carry_d = carry_q;
    if (ce) begin
      if (clear_PC)       pc_d = '0;
      else if (load_PC)   pc_d = ri_q[ADDR_W-1:0];
      else if (enable_PC) pc_d = pc_q + ADDR_W'(1);

      if (load_RI)   ri_d   = mem_rdata;
      if (load_R1)   r1_d   = mem_rdata;
      if (load_ACCU) accu_d = alu_res;

      if (clear_carry)     carry_d = 1'b0;
      else if (load_carry) carry_d = alu_cout;
    end
  end

  // Register bank with asynchronous active-high reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q    <= '0;
      ri_q    <= '0;
      r1_q    <= '0;
      accu_q  <= '0;
      carry_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      ri_q    <= ri_d;
      r1_q    <= r1_d;
      accu_q  <= accu_d;
      carry_q <= carry_d;
    end
  end

  // Zero-latency address mux: instruction fetch from PC, operand from RI
  assign mem_addr  = sel_ADR ? ri_q[ADDR_W-1:0] : pc_q;
  assign code_op   = ri_q[DATA_W-1:DATA_W-3];
  assign carry     = carry_q;
  assign mem_wdata = accu_q;
  assign accu_dbg  = accu_q;

endmodule
`default_nettype wire

// File: doc/ut_datapath.md
Name: ut_datapath

Overview:
Processing-unit datapath for the accumulator CPU, sitting directly downstream of the control FSM. It holds PC, instruction register RI, operand register R1, accumulator ACCU and the carry flag, and contains the ALU. It drives the memory address and write data, and returns code_op and carry to the FSM. Every register update is a one-to-one result of the FSM control strobes; the block makes no sequencing decisions of its own.

Parameters:
DATA_W, 8, memory word / ACCU / R1 / RI width; must be >= ADDR_W+3
ADDR_W, 5, memory address width; PC width

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
ce  in  1  clock enable; all register updates are gated by ce=1
clear_PC  in  1  PC <= 0
enable_PC  in  1  PC <= PC+1
load_PC  in  1  PC <= RI address field
load_RI  in  1  RI <= mem_rdata
sel_ADR  in  1  address mux: 0=PC, 1=RI address field
load_R1  in  1  R1 <= mem_rdata
load_ACCU  in  1  ACCU <= ALU result
sel_UAL  in  3  ALU operation select
clear_carry  in  1  carry <= 0
load_carry  in  1  carry <= ALU carry-out
mem_rdata  in  DATA_W  memory read data (synchronous RAM, 1-cycle read latency)
code_op  out  3  RI[DATA_W-1:DATA_W-3]
carry  out  1  carry flag register
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  = ACCU
accu_dbg  out  DATA_W  = ACCU, for observation only

Behaviour:
- Reset (rst=1, async): PC, RI, R1, ACCU = 0 and carry = 0. Therefore code_op=000, mem_addr=0, mem_wdata=0, accu_dbg=0. Reset mid-instruction discards all state immediately.
- ce=0: every register holds its value, whatever the strobes are. Combinational outputs still follow the current register values.
- PC priority: clear_PC > load_PC > enable_PC > hold.
  - load_PC takes RI[ADDR_W-1:0] as it was before the edge, so a simultaneous load_RI does not affect the loaded address.
  - Increment wraps modulo 2^ADDR_W (31 -> 0 at default).
- RI and R1 capture mem_rdata on the edge when their load is high. Back-to-back loads overwrite, and the last one wins.
- mem_addr is combinational: sel_ADR ? RI[ADDR_W-1:0] : PC. It has zero latency.
- ALU is combinational on ACCU (A) and R1 (B):
  - 000 NOR: res = ~(A|B); cout = 0.
  - 010 ADD: {cout,res} = A+B, computed at DATA_W+1 bits.
  - 011 SUB: {cout,res} = A + ~B + 1, computed at DATA_W+1 bits, so cout=1 means no borrow.
  - All other codes (001,100,101,110,111): res = A; cout = 0.
- ACCU <= res when load_ACCU is high.
- Carry priority: clear_carry > load_carry > hold. Carry is written only via load_carry. A NOR with load_carry=1 clears it (cout=0).
- All register updates happen on the same clk edge, and all read pre-edge values. A simultaneous load_ACCU and load_carry use the same ALU evaluation.
- No internal FSM. Latency from a strobe to the register output is 1 cycle. Memory-read strobes must land one cycle after the address has been presented; this is guaranteed by the controller's DLY states.

Test Plan:
- Reset: rst=1 with all registers preloaded non-zero -> all outputs 0 asynchronously, before the next clk edge.
- Fetch/decode: PC=3, sel_ADR=0 -> mem_addr=3. With mem_rdata=0x45, load_RI=1 -> code_op=010, and sel_ADR=1 gives mem_addr=0x05.
- ADD with carry: ACCU=0xF0, R1=0x20, sel_UAL=010, load_ACCU=1, load_carry=1 -> ACCU=0x10, carry=1. Then sel_UAL=000 NOR with R1=0x0F, load_carry=0 -> ACCU=0xE0 and carry stays 1.
- SUB: ACCU=0x05, R1=0x07, sel_UAL=011 -> ACCU=0xFE, carry=0. Then ACCU=0x07, R1=0x05 -> ACCU=0x02, carry=1.
- JCC-style strobes: RI=0xC9, carry=0, load_PC=1 with load_RI=1 and mem_rdata=0x00 -> PC=0x09 and RI=0x00. With carry=1: enable_PC=1 and clear_carry=1 -> PC+1 and carry=0.
- PC priority/wrap and ce: PC=31, enable_PC=1 -> PC=0. clear_PC=1 together with load_PC=1 -> PC=0. With ce=0 and all strobes high -> no register changes.
